// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, keeps at most one request in flight on
// the req/gnt/rvalid bus, buffers one instruction for decode and applies flush/JAL redirects.
module fetch_ctrl #(
   parameter int XLEN = 32,
   parameter int ILEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] start_address,
   input  logic            flush_i,
   input  logic [XLEN-1:0] flush_pc_i,
   input  logic            jal_i,
   input  logic [XLEN-1:0] jal_target_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [ILEN-1:0] imem_rdata_i,
   output logic            instr_valid_o,
   output logic [ILEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   input  logic            instr_ready_i
);

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_KILL = 2'd3;

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic [XLEN-1:0] instr_pc_q, instr_pc_d;
   logic [ILEN-1:0] instr_q, instr_d;
   logic            instr_valid_q, instr_valid_d;

   logic            accept;
   logic            grant;
   logic            flush_take;
   logic            jal_take;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;

   // A new request is only issued when the buffer is empty or being drained this cycle,
   // so a response can always land in the buffer without a second slot.
   assign imem_req_o    = (state_q == ST_REQ) && (!instr_valid_q || instr_ready_i);
   assign imem_addr_o   = fetch_pc_q;
   assign instr_valid_o = instr_valid_q;
   assign instr_o       = instr_q;
   assign instr_pc_o    = instr_pc_q;

   always_comb begin
      accept      = instr_valid_q && instr_ready_i;
      grant       = imem_req_o && imem_gnt_i;
      flush_take  = flush_i && (state_q != ST_BOOT);
      jal_take    = jal_i && accept && !flush_i && (state_q != ST_BOOT);
      redirect    = flush_take || jal_take;
      redirect_pc = flush_i ? flush_pc_i : jal_target_i;

      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      req_pc_d      = req_pc_q;
      instr_pc_d    = instr_pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;

      if (accept) begin
         instr_valid_d = 1'b0;
      end

      case (state_q)
         ST_BOOT: begin
            fetch_pc_d = {start_address[XLEN-1:2], 2'b00};
            state_d    = ST_REQ;
         end
         ST_REQ: begin
            if (grant) begin
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + PC_STEP;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid_i) begin
               if (!redirect) begin
                  instr_d       = imem_rdata_i;
                  instr_pc_d    = req_pc_q;
                  instr_valid_d = 1'b1;
               end
               state_d = ST_REQ;
            end
         end
         ST_KILL: begin
            if (imem_rvalid_i) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_BOOT;
      endcase

      // Redirect wins over sequential flow; any fetch still on the bus afterwards is stale.
      if (redirect) begin
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         if (flush_take) begin
            instr_valid_d = 1'b0;
         end
         if (grant || (((state_q == ST_WAIT) || (state_q == ST_KILL)) && !imem_rvalid_i)) begin
            state_d = ST_KILL;
         end else begin
            state_d = ST_REQ;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_BOOT;
         fetch_pc_q    <= '0;
         req_pc_q      <= '0;
         instr_pc_q    <= '0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         req_pc_q      <= req_pc_d;
         instr_pc_q    <= instr_pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
      end
   end

endmodule
